// File: rtl/fml_video_arbiter.sv
// -----------------------------------------------------------------------------
// fml_video_arbiter
//   Two-master arbiter in front of the single FML memory port. The text-mode
//   video fetcher (read-only, deadline-bound) has fixed priority over the CPU
//   bridge (read/write). A grant is held until the slave acks, and each grant
//   carries exactly one transaction. Every transaction is followed by one dead
//   IDLE cycle before the next arbitration.
//
//   Optional feature, selected by the macro FML_ARB_STARVE_GUARD_EN:
//     A 3-bit counter tracks consecutive video grants issued while the CPU is
//     waiting. Once it reaches STARVE_MAX, the next IDLE arbitration goes to
//     the CPU even when video is also requesting. Without the macro the
//     arbiter uses strict video priority and the counter is not built.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   vid_adr/stb     video read request (stb held until vid_ack)
//   vid_ack         video transaction complete (combinational from s_ack)
//   cpu_adr/stb/we/sel/do  CPU request (stb held until cpu_ack)
//   cpu_ack         CPU transaction complete (combinational from s_ack)
//   m_di            read data (s_di broadcast to both masters)
//   s_adr/stb/we/sel/do    registered slave request
//   s_ack, s_di     slave single-cycle ack and read data
// -----------------------------------------------------------------------------
module fml_video_arbiter #(
   parameter int fml_depth  = 25,
   parameter int STARVE_MAX = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [fml_depth-1:0] vid_adr,
   input  logic                 vid_stb,
   output logic                 vid_ack,
   input  logic [fml_depth-1:0] cpu_adr,
   input  logic                 cpu_stb,
   input  logic                 cpu_we,
   input  logic [1:0]           cpu_sel,
   input  logic [15:0]          cpu_do,
   output logic                 cpu_ack,
   output logic [15:0]          m_di,
   output logic [fml_depth-1:0] s_adr,
   output logic                 s_stb,
   output logic                 s_we,
   output logic [1:0]           s_sel,
   output logic [15:0]          s_do,
   input  logic                 s_ack,
   input  logic [15:0]          s_di
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_VID  = 2'd1,
      ST_CPU  = 2'd2
   } state_t;

   state_t r_state;
   state_t w_next;
   logic   w_grant_vid;
   logic   w_grant_cpu;
   logic   w_starve_fire;

`ifdef FML_ARB_STARVE_GUARD_EN
   localparam logic [2:0] LP_STARVE_MAX = 3'(STARVE_MAX);

   logic [2:0] r_starve_cnt;

   // The CPU overrides video only once it has waited through STARVE_MAX
   // consecutive video grants and is still requesting.
   assign w_starve_fire = (r_starve_cnt == LP_STARVE_MAX) && cpu_stb;

   // The counter only moves in IDLE, which is where grants are issued.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_starve_cnt <= 3'd0;
      end else if (r_state == ST_IDLE) begin
         if (w_grant_cpu || !cpu_stb) begin
            r_starve_cnt <= 3'd0;
         end else if (w_grant_vid && (r_starve_cnt != LP_STARVE_MAX)) begin
            r_starve_cnt <= r_starve_cnt + 3'd1;
         end
      end
   end
`else
   assign w_starve_fire = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Arbitration and next state
   always_comb begin
      w_next      = r_state;
      w_grant_vid = 1'b0;
      w_grant_cpu = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (vid_stb && !w_starve_fire) begin
               w_grant_vid = 1'b1;
               w_next      = ST_VID;
            end else if (cpu_stb) begin
               w_grant_cpu = 1'b1;
               w_next      = ST_CPU;
            end
         end
         ST_VID, ST_CPU: begin
            if (s_ack) begin
               w_next = ST_IDLE;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // Slave request registers: loaded on a grant, frozen until s_ack.
   always_ff @(posedge clk) begin
      if (rst) begin
         s_stb <= 1'b0;
         s_we  <= 1'b0;
         s_adr <= '0;
         s_sel <= 2'b00;
         s_do  <= 16'h0000;
      end else if (w_grant_vid) begin
         s_stb <= 1'b1;
         s_we  <= 1'b0;
         s_adr <= vid_adr;
         s_sel <= 2'b11;
      end else if (w_grant_cpu) begin
         s_stb <= 1'b1;
         s_we  <= cpu_we;
         s_adr <= cpu_adr;
         s_sel <= cpu_sel;
         s_do  <= cpu_do;
      end else if ((r_state != ST_IDLE) && s_ack) begin
         s_stb <= 1'b0;
      end
   end

   // Acks are gated by the current grant, so a stray s_ack in IDLE never
   // reaches either master.
   assign vid_ack = s_ack && (r_state == ST_VID);
   assign cpu_ack = s_ack && (r_state == ST_CPU);
   assign m_di    = s_di;

endmodule
